// File: rtl/eth_pkg.sv
// Shared types for the Ethernet clock/reset sequencer: FSM state encoding and
// a small elaboration-time helper.
package eth_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff_eth.sv
// Two-flop synchroniser for a single asynchronous level, synchronously reset.
module sync_2ff_eth (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_seq_eth.sv
// MMCM reset / lock-qualification sequencer with staggered per-channel reset
// release, bounded relock retries and a sticky fault state.
module clk_rst_seq_eth
  import eth_pkg::*;
#(
  parameter int unsigned NUM_CH             = 3,
  parameter int unsigned LOCK_FILT_CYC      = 1024,
  parameter int unsigned RST_PULSE_CYC      = 16,
  parameter int unsigned RELOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned STAGGER_CYC        = 8,
  parameter int unsigned MAX_RETRY          = 3
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               mmcm_locked_in,
  input  logic                               sw_rst_req_in,
  output logic                               mmcm_rst_out,
  output logic [NUM_CH-1:0]                  ch_rst_n_out,
  output logic                               all_ready_out,
  output logic                               fault_out,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt_out,
  output logic [STATE_W-1:0]                 state_out
);

  localparam int unsigned RW      = $clog2(MAX_RETRY + 1);
  localparam int unsigned REL_END = NUM_CH * STAGGER_CYC;
  localparam int unsigned CNT_MAX = max_u(max_u(RST_PULSE_CYC, RELOCK_TIMEOUT_CYC),
                                          max_u(LOCK_FILT_CYC, REL_END));
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic              lock_s;
  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0]     retry_q, retry_d, retry_inc;
  logic              fault_d;
  logic              mmcm_rst_d;
  logic              ready_d;
  logic [NUM_CH-1:0] ch_d;

  sync_2ff_eth u_lock_sync (
    .clk   (clk_in),
    .rst_n (rst_in),
    .d     (mmcm_locked_in),
    .q     (lock_s)
  );

  // One phase counter is shared by every state; it restarts on each transition.
  assign cnt_inc   = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
  assign retry_inc = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + RW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fault_d = fault_out;

    case (state_q)
      ST_MMCM_RST: begin
        if (cnt_q >= CW'(RST_PULSE_CYC - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_FILTER;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(RELOCK_TIMEOUT_CYC - 1)) begin
          cnt_d   = '0;
          retry_d = retry_inc;
          state_d = (retry_inc >= RW'(MAX_RETRY)) ? ST_FAULT : ST_MMCM_RST;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FILTER: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(LOCK_FILT_CYC - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          state_d = ST_MMCM_RST;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(REL_END)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_MMCM_RST;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_MMCM_RST;
        cnt_d   = '0;
      end
    endcase

    if (state_d == ST_FAULT) begin
      fault_d = 1'b1;
    end

    // Software request outranks every lock event evaluated above.
    if (sw_rst_req_in) begin
      state_d = ST_MMCM_RST;
      cnt_d   = '0;
      retry_d = '0;
      fault_d = 1'b0;
    end

    mmcm_rst_d = (state_d == ST_MMCM_RST);
    ready_d    = (state_d == ST_RUN);
    ch_d       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_d[k] = (state_d == ST_RUN) ||
                ((state_d == ST_RELEASE) && (cnt_d >= CW'((k + 1) * STAGGER_CYC)));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_MMCM_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      mmcm_rst_out  <= 1'b1;
      ch_rst_n_out  <= '0;
      all_ready_out <= 1'b0;
      fault_out     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      mmcm_rst_out  <= mmcm_rst_d;
      ch_rst_n_out  <= ch_d;
      all_ready_out <= ready_d;
      fault_out     <= fault_d;
    end
  end

  assign state_out     = state_q;
  assign retry_cnt_out = retry_q;

endmodule

// File: tb/tb_clk_rst_seq_eth.sv
// Directed + randomized bench for clk_rst_seq_eth, checked every cycle against
// a timestamp-based phase model of the sequencing rules.
module tb_clk_rst_seq_eth;
  import eth_pkg::*;

  localparam int NUM_CH    = 3;
  localparam int FILT      = 8;
  localparam int PULSE     = 4;
  localparam int TIMEOUT   = 32;
  localparam int STAGGER   = 2;
  localparam int MAX_RETRY = 2;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic       sw;
  logic       mmcm_rst_out;
  logic [2:0] ch_rst_n_out;
  logic       all_ready_out;
  logic       fault_out;
  logic [1:0] retry_cnt_out;
  logic [2:0] state_out;

  int checks   = 0;
  int failures = 0;

  clk_rst_seq_eth #(
    .NUM_CH             (NUM_CH),
    .LOCK_FILT_CYC      (FILT),
    .RST_PULSE_CYC      (PULSE),
    .RELOCK_TIMEOUT_CYC (TIMEOUT),
    .STAGGER_CYC        (STAGGER),
    .MAX_RETRY          (MAX_RETRY)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .mmcm_locked_in (lock),
    .sw_rst_req_in  (sw),
    .mmcm_rst_out   (mmcm_rst_out),
    .ch_rst_n_out   (ch_rst_n_out),
    .all_ready_out  (all_ready_out),
    .fault_out      (fault_out),
    .retry_cnt_out  (retry_cnt_out),
    .state_out      (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current phase, the edge index it was entered at, and a
  // two-edge delay line standing in for the lock synchroniser.
  seq_state_e m_phase = ST_MMCM_RST;
  int         m_t     = 0;
  int         m_t0    = 0;
  int         m_retry = 0;
  bit         m_fault = 1'b0;
  bit         dly[$];

  function automatic void enter(input seq_state_e s);
    m_phase = s;
    m_t0    = m_t;
  endfunction

  function automatic void model_edge();
    bit ls;
    int el;
    m_t++;
    if (!rst_n) begin
      dly = '{1'b0, 1'b0};
      enter(ST_MMCM_RST);
      m_retry = 0;
      m_fault = 1'b0;
      return;
    end
    ls = dly.pop_front();
    dly.push_back(lock);
    if (sw) begin
      enter(ST_MMCM_RST);
      m_retry = 0;
      m_fault = 1'b0;
      return;
    end
    el = m_t - m_t0;
    case (m_phase)
      ST_MMCM_RST:  if (el == PULSE) enter(ST_WAIT_LOCK);
      ST_WAIT_LOCK: begin
        if (ls) enter(ST_FILTER);
        else if (el == TIMEOUT) begin
          m_retry++;
          if (m_retry == MAX_RETRY) begin
            enter(ST_FAULT);
            m_fault = 1'b1;
          end else begin
            enter(ST_MMCM_RST);
          end
        end
      end
      ST_FILTER: begin
        if (!ls) enter(ST_WAIT_LOCK);
        else if (el == FILT) enter(ST_RELEASE);
      end
      ST_RELEASE: begin
        if (!ls) enter(ST_MMCM_RST);
        else if (el == NUM_CH * STAGGER + 1) begin
          enter(ST_RUN);
          m_retry = 0;
        end
      end
      ST_RUN:   if (!ls) enter(ST_MMCM_RST);
      default:  ;
    endcase
  endfunction

  function automatic logic [10:0] model_out();
    logic [2:0] ch;
    int el;
    el = m_t - m_t0;
    ch = '0;
    for (int k = 0; k < NUM_CH; k++)
      ch[k] = (m_phase == ST_RUN) || (m_phase == ST_RELEASE && el >= (k + 1) * STAGGER);
    return {3'(m_phase), (m_phase == ST_MMCM_RST), ch, (m_phase == ST_RUN), m_fault, 2'(m_retry)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [10:0] obs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    obs = {state_out, mmcm_rst_out, ch_rst_n_out, all_ready_out, fault_out, retry_cnt_out};
    chk("cycle_model", 32'(obs), 32'(model_out()));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state_out !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(state_out), 32'(s));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_out), 32'(ST_MMCM_RST));
    chk({tag, "_mmcm"},  32'(mmcm_rst_out), 32'd1);
    chk({tag, "_ch"},    32'(ch_rst_n_out), 32'd0);
    chk({tag, "_ready"}, 32'(all_ready_out), 32'd0);
    chk({tag, "_fault"}, 32'(fault_out), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt_out), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    bit seen1;
    logic [2:0] exp_ch;

    dly   = '{1'b0, 1'b0};
    rst_n = 1'b0;
    lock  = 1'b0;
    sw    = 1'b0;
    repeat (3) tick();
    chk_reset_values("reset");

    // Nominal bring-up: lock rises 10 cycles after reset release.
    rst_n = 1'b1;
    repeat (10) tick();
    lock = 1'b1;
    wait_state("nom_reach_release", ST_RELEASE, 100, n);
    for (int j = 1; j <= 7; j++) begin
      tick();
      exp_ch = '0;
      for (int k = 0; k < NUM_CH; k++) exp_ch[k] = (j >= (k + 1) * STAGGER);
      chk("nom_ch_stagger", 32'(ch_rst_n_out), 32'(exp_ch));
      chk("nom_ready", 32'(all_ready_out), (j == 7) ? 32'd1 : 32'd0);
    end

    // Lock glitch inside the filter window restarts qualification.
    lock = 1'b0;
    sw   = 1'b1;
    tick();
    sw   = 1'b0;
    wait_state("glitch_wait", ST_WAIT_LOCK, 20, n);
    lock = 1'b1;
    repeat (5) tick();
    chk("glitch_in_filter", 32'(state_out), 32'(ST_FILTER));
    lock = 1'b0;
    tick();
    lock = 1'b1;
    tick();
    tick();
    chk("glitch_back_to_wait", 32'(state_out), 32'(ST_WAIT_LOCK));
    chk("glitch_no_early_ch", 32'(ch_rst_n_out), 32'd0);
    wait_state("glitch_reach_release", ST_RELEASE, 40, n);
    chk("glitch_filter_restart", 32'(n), 32'd9);
    wait_state("glitch_reach_run", ST_RUN, 20, n);

    // Lock loss while running.
    lock = 1'b0;
    n = 0;
    while (ch_rst_n_out !== 3'b000 && n < 10) begin
      tick();
      n++;
    end
    chk("loss_ch_clear_latency", 32'(n), 32'd3);
    m = 0;
    while (mmcm_rst_out === 1'b1 && m < 20) begin
      m++;
      tick();
    end
    chk("loss_mmcm_pulse", 32'(m), 32'd4);
    chk("loss_state_wait", 32'(state_out), 32'(ST_WAIT_LOCK));
    repeat ($urandom_range(0, 15)) tick();
    lock = 1'b1;
    wait_state("loss_resequence", ST_RUN, 60, n);

    // Lock never arrives: two timeouts then fault.
    lock  = 1'b0;
    sw    = 1'b1;
    tick();
    sw    = 1'b0;
    n     = 0;
    seen1 = 1'b0;
    while (state_out !== ST_FAULT && n < 200) begin
      tick();
      n++;
      if (retry_cnt_out === 2'd1) seen1 = 1'b1;
    end
    chk("timeout_cycles", 32'(n), 32'd72);
    chk("timeout_retry1_seen", 32'(seen1), 32'd1);
    chk("timeout_fault", 32'(fault_out), 32'd1);
    chk("timeout_mmcm_low", 32'(mmcm_rst_out), 32'd0);
    chk("timeout_retry2", 32'(retry_cnt_out), 32'd2);
    chk("timeout_ch_held", 32'(ch_rst_n_out), 32'd0);
    for (int i = 0; i < 20; i++) begin
      lock = 1'($urandom_range(0, 1));
      tick();
    end
    chk("fault_sticky", 32'(state_out), 32'(ST_FAULT));

    // Software request out of FAULT, and coincident with a lock drop.
    lock = 1'b1;
    sw   = 1'b1;
    tick();
    sw   = 1'b0;
    chk("sw_fault_state", 32'(state_out), 32'(ST_MMCM_RST));
    chk("sw_fault_clr", 32'(fault_out), 32'd0);
    chk("sw_retry_clr", 32'(retry_cnt_out), 32'd0);
    wait_state("sw_reach_run", ST_RUN, 60, n);
    lock = 1'b0;
    tick();
    tick();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    chk("simul_state", 32'(state_out), 32'(ST_MMCM_RST));
    chk("simul_fault", 32'(fault_out), 32'd0);
    chk("simul_retry", 32'(retry_cnt_out), 32'd0);
    chk("simul_ch", 32'(ch_rst_n_out), 32'd0);

    // Reset asserted mid-release.
    lock = 1'b1;
    wait_state("midrel_reach_release", ST_RELEASE, 60, n);
    n = 0;
    while (ch_rst_n_out[0] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("midrel_ch0_up", 32'(ch_rst_n_out), 32'b001);
    rst_n = 1'b0;
    tick();
    chk_reset_values("midrel_reset");
    rst_n = 1'b1;

    // Randomized lock waveform with sporadic software requests and resets.
    for (int seg = 0; seg < 60; seg++) begin
      lock = ($urandom_range(0, 3) != 0);
      for (int c = 0, len = int'($urandom_range(1, 50)); c < len; c++) begin
        sw    = ($urandom_range(0, 199) == 0);
        rst_n = ($urandom_range(0, 299) != 0);
        tick();
        sw    = 1'b0;
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
